// File: rtl/adc_readout_seq_if.sv
// FIFO write-port bundle for the two readout channels (Avalon-ST style
// writedata/write/waitrequest). The sequencer is the master, the FIFOs the slave.
interface adc_readout_seq_if;
    logic [31:0] fifo0_writedata;
    logic        fifo0_write;
    logic        fifo0_waitrequest;
    logic [31:0] fifo1_writedata;
    logic        fifo1_write;
    logic        fifo1_waitrequest;

    modport master (
        output fifo0_writedata, fifo0_write,
        output fifo1_writedata, fifo1_write,
        input  fifo0_waitrequest, fifo1_waitrequest
    );

    modport slave (
        input  fifo0_writedata, fifo0_write,
        input  fifo1_writedata, fifo1_write,
        output fifo0_waitrequest, fifo1_waitrequest
    );
endinterface

// File: rtl/adc_readout_seq.sv
// Two-channel ADC readout sequencer. A rising trigger edge (while armed and idle)
// starts an event: a header word {A5, event count} goes to both FIFOs, then
// nwords packed words per channel (two zero-extended samples per word), then the
// sequencer waits for both FIFOs to drain and pulses done.
module adc_readout_seq #(
    parameter int ADC_W = 12,
    parameter int NW_W  = 10,
    parameter int EVT_W = 24
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              arm,
    input  logic              trig,
    input  logic [NW_W-1:0]   nwords,
    input  logic              adc_valid,
    input  logic [ADC_W-1:0]  adc0_data,
    input  logic [ADC_W-1:0]  adc1_data,
    adc_readout_seq_if.master fifo,
    output logic              busy,
    output logic              done,
    output logic              ovf0,
    output logic              ovf1,
    output logic [EVT_W-1:0]  evt_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        CAPTURE = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    // Two samples per 32-bit word, each zero-extended into a 16-bit half;
    // the earlier sample sits in the low half.
    function automatic logic [31:0] pack_word(input logic [ADC_W-1:0] hi,
                                              input logic [ADC_W-1:0] lo);
        return {16'(hi), 16'(lo)};
    endfunction

    // Header carries a fixed marker byte and the event number of this event.
    function automatic logic [31:0] header_word(input logic [EVT_W-1:0] cnt);
        return {8'hA5, 24'(cnt)};
    endfunction

    state_t            state_q,    state_d;
    logic              trig_dly_q, trig_dly_d;
    logic [NW_W-1:0]   nwords_q,   nwords_d;
    logic [NW_W-1:0]   word_cnt_q, word_cnt_d;
    logic [EVT_W-1:0]  evt_cnt_q,  evt_cnt_d;
    logic              phase_q,    phase_d;
    logic [ADC_W-1:0]  low0_q,     low0_d;
    logic [ADC_W-1:0]  low1_q,     low1_d;
    logic [31:0]       wdata0_q,   wdata0_d;
    logic [31:0]       wdata1_q,   wdata1_d;
    logic              wr0_q,      wr0_d;
    logic              wr1_q,      wr1_d;
    logic              ovf0_q,     ovf0_d;
    logic              ovf1_q,     ovf1_d;
    logic              done_q,     done_d;

    logic              acc0, acc1;
    logic              clear0, clear1;
    logic              trig_edge;
    logic [NW_W-1:0]   word_cnt_inc;
    logic [31:0]       word0, word1;

    assign acc0         = wr0_q & ~fifo.fifo0_waitrequest;
    assign acc1         = wr1_q & ~fifo.fifo1_waitrequest;
    // A channel can take a new word this cycle if nothing is pending or the
    // pending word is being accepted right now.
    assign clear0       = ~wr0_q | acc0;
    assign clear1       = ~wr1_q | acc1;
    assign trig_edge    = trig & ~trig_dly_q;
    assign word_cnt_inc = word_cnt_q + 1'b1;
    assign word0        = pack_word(adc0_data, low0_q);
    assign word1        = pack_word(adc1_data, low1_q);

    // Next-state logic for the sequencer, sample packer and both write ports.
    always_comb begin
        state_d    = state_q;
        trig_dly_d = trig;
        nwords_d   = nwords_q;
        word_cnt_d = word_cnt_q;
        evt_cnt_d  = evt_cnt_q;
        phase_d    = phase_q;
        low0_d     = low0_q;
        low1_d     = low1_q;
        wdata0_d   = wdata0_q;
        wdata1_d   = wdata1_q;
        wr0_d      = wr0_q & ~acc0;
        wr1_d      = wr1_q & ~acc1;
        ovf0_d     = ovf0_q;
        ovf1_d     = ovf1_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig_edge && arm) begin
                    state_d    = HEADER;
                    nwords_d   = nwords;
                    word_cnt_d = '0;
                    phase_d    = 1'b0;
                    evt_cnt_d  = evt_cnt_q + 1'b1;
                    wdata0_d   = header_word(evt_cnt_q);
                    wdata1_d   = header_word(evt_cnt_q);
                    wr0_d      = 1'b1;
                    wr1_d      = 1'b1;
                    ovf0_d     = 1'b0;
                    ovf1_d     = 1'b0;
                end
            end
            HEADER: begin
                // Samples arriving here are discarded; capture starts only once
                // both FIFOs hold the header.
                if (clear0 && clear1) begin
                    state_d = (nwords_q == '0) ? FLUSH : CAPTURE;
                end
            end
            CAPTURE: begin
                if (adc_valid) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        low0_d  = adc0_data;
                        low1_d  = adc1_data;
                    end else begin
                        phase_d    = 1'b0;
                        word_cnt_d = word_cnt_inc;
                        // A dropped word still counts toward the event length.
                        if (clear0) begin
                            wdata0_d = word0;
                            wr0_d    = 1'b1;
                        end else begin
                            ovf0_d = 1'b1;
                        end
                        if (clear1) begin
                            wdata1_d = word1;
                            wr1_d    = 1'b1;
                        end else begin
                            ovf1_d = 1'b1;
                        end
                        if (word_cnt_inc == nwords_q) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (clear0 && clear1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any event in flight.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= IDLE;
            trig_dly_q <= 1'b0;
            nwords_q   <= '0;
            word_cnt_q <= '0;
            evt_cnt_q  <= '0;
            phase_q    <= 1'b0;
            low0_q     <= '0;
            low1_q     <= '0;
            wdata0_q   <= '0;
            wdata1_q   <= '0;
            wr0_q      <= 1'b0;
            wr1_q      <= 1'b0;
            ovf0_q     <= 1'b0;
            ovf1_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_dly_q <= trig_dly_d;
            nwords_q   <= nwords_d;
            word_cnt_q <= word_cnt_d;
            evt_cnt_q  <= evt_cnt_d;
            phase_q    <= phase_d;
            low0_q     <= low0_d;
            low1_q     <= low1_d;
            wdata0_q   <= wdata0_d;
            wdata1_q   <= wdata1_d;
            wr0_q      <= wr0_d;
            wr1_q      <= wr1_d;
            ovf0_q     <= ovf0_d;
            ovf1_q     <= ovf1_d;
            done_q     <= done_d;
        end
    end

    assign fifo.fifo0_writedata = wdata0_q;
    assign fifo.fifo0_write     = wr0_q;
    assign fifo.fifo1_writedata = wdata1_q;
    assign fifo.fifo1_write     = wr1_q;
    assign busy                 = (state_q != IDLE);
    assign done                 = done_q;
    assign ovf0                 = ovf0_q;
    assign ovf1                 = ovf1_q;
    assign evt_cnt              = evt_cnt_q;

endmodule

// File: tb/tb_adc_readout_seq.sv
// Testbench for adc_readout_seq: directed scenarios plus randomized events,
// checked against a timestamp-based event model. A second instance with a
// 4-bit event counter exercises counter wrap in the header.
module tb_adc_readout_seq;
    localparam int MAXC = 8192;
    localparam int NEVER = 1 << 30;

    logic        clk = 1'b0;
    logic        rst, arm, trig, adc_valid;
    logic [9:0]  nwords;
    logic [11:0] adc0, adc1;
    logic        busy, done, ovf0, ovf1;
    logic [23:0] evt_cnt;
    logic        busy2, done2, ovf0_2, ovf1_2;
    logic [3:0]  evt2;

    always #5 clk = ~clk;

    adc_readout_seq_if fif ();
    adc_readout_seq_if fif2 ();

    adc_readout_seq dut (
        .clk_clk(clk), .reset_reset(rst), .arm(arm), .trig(trig), .nwords(nwords),
        .adc_valid(adc_valid), .adc0_data(adc0), .adc1_data(adc1), .fifo(fif),
        .busy(busy), .done(done), .ovf0(ovf0), .ovf1(ovf1), .evt_cnt(evt_cnt)
    );

    adc_readout_seq #(.EVT_W(4)) dut2 (
        .clk_clk(clk), .reset_reset(rst), .arm(arm), .trig(trig), .nwords(nwords),
        .adc_valid(adc_valid), .adc0_data(adc0), .adc1_data(adc1), .fifo(fif2),
        .busy(busy2), .done(done2), .ovf0(ovf0_2), .ovf1(ovf1_2), .evt_cnt(evt2)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cyc;
    int evt_model = 0;
    bit          w0a [MAXC];
    bit          w1a [MAXC];
    bit          va  [MAXC];
    bit          busya [MAXC];
    logic [11:0] d0a [MAXC];
    logic [11:0] d1a [MAXC];
    logic [31:0] got0[$], got1[$], exp0[$], exp1[$];
    logic [31:0] hdr2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: record this cycle's inputs and observed handshakes, then advance.
    task automatic step();
        if (cyc >= MAXC - 1) begin
            $display("FAIL cycle_budget: got %0d expected < %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        w0a[cyc]   = fif.fifo0_waitrequest;
        w1a[cyc]   = fif.fifo1_waitrequest;
        va[cyc]    = adc_valid;
        d0a[cyc]   = adc0;
        d1a[cyc]   = adc1;
        busya[cyc] = busy;
        if (fif.fifo0_write && !fif.fifo0_waitrequest) got0.push_back(fif.fifo0_writedata);
        if (fif.fifo1_write && !fif.fifo1_waitrequest) got1.push_back(fif.fifo1_writedata);
        if (done && done_cyc < 0) done_cyc = cyc;
        if (fif2.fifo0_write && fif2.fifo0_writedata[31:24] == 8'hA5) hdr2 = fif2.fifo0_writedata;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // First cycle at or after 'from' in which the given FIFO is not stalling.
    function automatic int first_acc(input int ch, input int from);
        for (int c = from; c < cyc; c++) begin
            if (ch == 0 ? !w0a[c] : !w1a[c]) return c;
        end
        return NEVER;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Run one armed event. pw/pv: percent chance of waitrequest / adc_valid per
    // cycle; lo/hi: cycle window (relative to the trigger) where a FIFO is forced
    // to stall; seq: sample values count 1,2,3.. from the first capture cycle.
    task automatic run_event(input int n, input int pw, input int pv,
                             input int lo0, input int hi0, input int lo1, input int hi1,
                             input bit seq);
        int T, H, k, L0, L1, ed, prev;
        bit half, eo0, eo1;
        logic [11:0] l0, l1;
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
        done_cyc = -1;
        hdr2 = '0;
        trig = 1'b0; arm = 1'b1; adc_valid = 1'b0;
        fif.fifo0_waitrequest = 1'b0; fif.fifo1_waitrequest = 1'b0;
        step();
        T = cyc;
        nwords = 10'(n);
        for (int i = 0; i < 2000 && done_cyc < 0; i++) begin
            int r;
            r = cyc - T;
            trig = (r == 0) || (r == 2);
            if (r > 0) begin
                arm = 1'($urandom);
                nwords = 10'($urandom);
            end
            fif.fifo0_waitrequest = (r >= lo0 && r <= hi0) || ($urandom_range(99) < 32'(pw));
            fif.fifo1_waitrequest = (r >= lo1 && r <= hi1) || ($urandom_range(99) < 32'(pw));
            adc_valid = ($urandom_range(99) < 32'(pv));
            if (seq) begin
                adc0 = 12'(r - 1);
                adc1 = 12'h100 + 12'(r - 1);
            end else begin
                adc0 = 12'($urandom);
                adc1 = 12'($urandom);
            end
            step();
        end
        trig = 1'b0; arm = 1'b1;
        fif.fifo0_waitrequest = 1'b0; fif.fifo1_waitrequest = 1'b0;
        if (done_cyc < 0) begin
            chk("done_timeout", 32'(done_cyc), 32'(T));
            return;
        end
        chk("done_pulse_len", 32'(done), 32'd0);

        // Event model: header first, then one word per two counted samples,
        // with a word dropped whenever the previous one is still unaccepted.
        prev = evt_model;
        exp0.push_back({8'hA5, 24'(evt_model)});
        exp1.push_back({8'hA5, 24'(evt_model)});
        H = imax(first_acc(0, T + 1), first_acc(1, T + 1));
        eo0 = 1'b0; eo1 = 1'b0;
        if (n == 0) begin
            ed = H + 2;
        end else begin
            k = 0; half = 1'b0; L0 = T + 1; L1 = T + 1; l0 = '0; l1 = '0;
            for (int c = H + 1; c < cyc && k < n; c++) begin
                if (va[c]) begin
                    if (!half) begin
                        l0 = d0a[c]; l1 = d1a[c]; half = 1'b1;
                    end else begin
                        half = 1'b0;
                        k++;
                        if (first_acc(0, L0) > c) eo0 = 1'b1;
                        else begin exp0.push_back({4'h0, d0a[c], 4'h0, l0}); L0 = c + 1; end
                        if (first_acc(1, L1) > c) eo1 = 1'b1;
                        else begin exp1.push_back({4'h0, d1a[c], 4'h0, l1}); L1 = c + 1; end
                    end
                end
            end
            ed = imax(first_acc(0, L0), first_acc(1, L1)) + 1;
        end
        evt_model++;

        chk("fifo0_count", 32'(got0.size()), 32'(exp0.size()));
        chk("fifo1_count", 32'(got1.size()), 32'(exp1.size()));
        for (int i = 0; i < got0.size() && i < exp0.size(); i++) chk("fifo0_word", got0[i], exp0[i]);
        for (int i = 0; i < got1.size() && i < exp1.size(); i++) chk("fifo1_word", got1[i], exp1[i]);
        chk("ovf0", 32'(ovf0), 32'(eo0));
        chk("ovf1", 32'(ovf1), 32'(eo1));
        chk("done_cycle", 32'(done_cyc - T), 32'(ed - T));
        chk("busy_after_trig", 32'(busya[T + 1]), 32'd1);
        chk("busy_before_done", 32'(busya[done_cyc - 1]), 32'd1);
        chk("busy_at_done", 32'(busya[done_cyc]), 32'd0);
        chk("evt_cnt", 32'(evt_cnt), 32'(evt_model) & 32'h00FF_FFFF);
        chk("evt_cnt_w4", 32'(evt2), 32'(evt_model % 16));
        chk("header_w4", hdr2, {8'hA5, 20'h0, 4'(prev)});
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; trig = 1'b0; nwords = '0; adc_valid = 1'b0;
        adc0 = '0; adc1 = '0;
        fif.fifo0_waitrequest = 1'b0; fif.fifo1_waitrequest = 1'b0;
        fif2.fifo0_waitrequest = 1'b0; fif2.fifo1_waitrequest = 1'b0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_write0", 32'(fif.fifo0_write), 32'd0);
        chk("rst_write1", 32'(fif.fifo1_write), 32'd0);
        chk("rst_wdata0", fif.fifo0_writedata, 32'd0);
        chk("rst_evt", 32'(evt_cnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'({ovf0, ovf1}), 32'd0);
        rst = 1'b0;
        step();

        // Basic event with known samples
        run_event(2, 0, 100, -1, -2, -1, -2, 1'b1);
        if (got0.size() == 3) begin
            chk("t1_f0_w0", got0[0], 32'hA500_0000);
            chk("t1_f0_w1", got0[1], 32'h0002_0001);
            chk("t1_f0_w2", got0[2], 32'h0004_0003);
        end
        if (got1.size() == 3) begin
            chk("t1_f1_w0", got1[0], 32'hA500_0000);
            chk("t1_f1_w1", got1[1], 32'h0102_0101);
            chk("t1_f1_w2", got1[2], 32'h0104_0103);
        end

        // fifo1 stalls the header for 10 cycles
        run_event(3, 0, 100, -1, -2, 1, 10, 1'b0);
        chk("t2_f0_words", 32'(got0.size()), 32'd4);

        // fifo0 stalls across the second word completion
        run_event(3, 0, 100, 3, 6, -1, -2, 1'b0);
        chk("t3_ovf0", 32'(ovf0), 32'd1);
        chk("t3_f0_words", 32'(got0.size()), 32'd3);
        chk("t3_f1_words", 32'(got1.size()), 32'd4);

        // Unarmed trigger is ignored
        got0.delete(); got1.delete();
        arm = 1'b0; trig = 1'b0; step();
        trig = 1'b1; step();
        repeat (3) step();
        arm = 1'b1; repeat (3) step();
        trig = 1'b0; repeat (2) step();
        chk("unarmed_f0", 32'(got0.size()), 32'd0);
        chk("unarmed_f1", 32'(got1.size()), 32'd0);
        chk("unarmed_busy", 32'(busy), 32'd0);
        chk("unarmed_evt", 32'(evt_cnt), 32'(evt_model));
        run_event(1, 0, 100, -1, -2, -1, -2, 1'b0);

        // Randomized events; count passes 16 so the 4-bit instance wraps
        for (int e = 0; e < 20; e++) begin
            run_event($urandom_range(0, 10), $urandom_range(0, 40), $urandom_range(30, 100),
                      -1, -2, -1, -2, 1'b0);
        end

        // Reset in the middle of capture with a write pending
        trig = 1'b0; arm = 1'b1; adc_valid = 1'b1; nwords = 10'd8;
        fif.fifo0_waitrequest = 1'b0; fif.fifo1_waitrequest = 1'b0;
        step();
        trig = 1'b1; step();
        trig = 1'b0;
        for (int r = 1; r <= 7; r++) begin
            fif.fifo0_waitrequest = (r >= 2);
            step();
        end
        chk("pre_rst_write0", 32'(fif.fifo0_write), 32'd1);
        chk("pre_rst_ovf0", 32'(ovf0), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1; step();
        rst = 1'b0;
        fif.fifo0_waitrequest = 1'b0; adc_valid = 1'b0;
        evt_model = 0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_write0", 32'(fif.fifo0_write), 32'd0);
        chk("mid_rst_write1", 32'(fif.fifo1_write), 32'd0);
        chk("mid_rst_wdata0", fif.fifo0_writedata, 32'd0);
        chk("mid_rst_wdata1", fif.fifo1_writedata, 32'd0);
        chk("mid_rst_ovf", 32'({ovf0, ovf1}), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_evt", 32'(evt_cnt), 32'd0);
        chk("mid_rst_evt_w4", 32'(evt2), 32'd0);
        run_event(2, 10, 80, -1, -2, -1, -2, 1'b0);
        if (got0.size() > 0) chk("post_rst_header", got0[0], 32'hA500_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_readout_seq.md
# adc_readout_seq

Readout sequencer for the two-channel ADC test path. On an external trigger it writes a header word, then packs a fixed number of 12-bit ADC samples per channel, two per word, into 32-bit words. These are pushed through the two Avalon-ST-style FIFO write ports (writedata/write/waitrequest) of the readout system. It sits between the ADC capture logic and the system's fifo_0_in / fifo_1_in ports, is armed by the system's write-enable export, and is fired by its external-trigger export.

## Interface
- ADC_W, 12, sample width; samples zero-extended to 16 bits in a packed word
- NW_W, 10, width of the word-count configuration
- EVT_W, 24, width of the event counter carried in the header
- clk_clk  in  1  single clock; all logic rising-edge
- reset_reset  in  1  synchronous, active-high reset
- arm  in  1  write-enable; a trigger is accepted only while high
- trig  in  1  external trigger level; rising edge detected internally
- nwords  in  NW_W  data words per channel per event; latched at trigger
- adc_valid  in  1  one sample per channel present this cycle
- adc0_data, adc1_data  in  ADC_W  channel samples
- fifo0_writedata, fifo1_writedata  out  32  word to FIFO
- fifo0_write, fifo1_write  out  1  write request, held until accepted
- fifo0_waitrequest, fifo1_waitrequest  in  1  FIFO stall
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of event
- ovf0, ovf1  out  1  sticky per-channel word-drop flag
- evt_cnt  out  EVT_W  events accepted so far

## Operation
- Trigger: trig_d is trig registered. The edge is trig & ~trig_d. An edge is accepted only in IDLE with arm=1; edges in any other state or with arm=0 are ignored.
- Latch on accept: nwords, header word {8'hA5, evt_cnt}, evt_cnt+1 (wraps 2^EVT_W-1 → 0); ovf0 and ovf1 are cleared.
- FSM IDLE → HEADER → CAPTURE → FLUSH → IDLE.
- HEADER: both FIFOs are presented the header word. The FSM leaves for CAPTURE when both have accepted it. If nwords=0 it goes to FLUSH instead. adc_valid is ignored in HEADER.
- CAPTURE:
  - Each adc_valid cycle is one sample per channel. A phase bit toggles per sample.
  - Phase 0 stores the sample as the low half. Phase 1 completes the word {4'h0, s1, 4'h0, s0} (ADC_W=12).
  - The word counter increments on each completed word. After the nwords-th word the FSM goes to FLUSH.
- Per-channel pending register: a completed word loads the register and asserts write.
  - If a previous word is still pending and is not accepted in the completion cycle, the new word is dropped and ovfN is set. The dropped word still counts toward nwords.
  - If the previous word is accepted in that same cycle, the new word loads without loss.
- FLUSH: the FSM waits until both pending writes are accepted. It then returns to IDLE and pulses done.
- Write handshake: writedata is stable while write=1. A word is accepted in a cycle with write=1 and waitrequest=0, and write drops the next cycle unless a new word loads.
- arm falling mid-event has no effect; the event runs to completion.
- nwords and arm changes during an event are ignored.
- Reset values: all outputs 0; state IDLE; trig_d=0; evt_cnt=0. Reset mid-event abandons the event, and write drops the cycle after reset is sampled.

## Timing
- Edge sampled at cycle T (trig=1, trig_d=0, IDLE, arm=1) → busy=1 and both write=1 with header at T+1.
- Header accepted by both FIFOs at cycle H → CAPTURE at H+1. The first sample counted is the first adc_valid at or after H+1.
- Phase-1 sample at cycle S → write=1 with that word at S+1.
- Last accept at cycle F in FLUSH → done=1 and busy=0 at F+1; the next trigger is accepted at F+1 at earliest.
- With waitrequest always 0, each write is one cycle. An event with n words at full sample rate has no drops.

## Test plan
- nwords=2, evt_cnt=0, waitrequest=0, adc_valid continuous, samples ch0 0x001..0x004, ch1 0x101..0x104 → fifo0 receives A5000000, 00020001, 00040003; fifo1 receives A5000000, 01020101, 01040103; then done pulse; ovf0=ovf1=0.
- fifo1_waitrequest held high 10 cycles during HEADER → no CAPTURE until the fifo1 header is accepted; samples before then are discarded; fifo0 header is written once only.
- nwords=3, fifo0_waitrequest high for 4 cycles across the 2nd-word completion with continuous adc_valid → ovf0=1, fifo0 receives header plus 2 data words, fifo1 receives header plus 3 data words, done still pulses.
- Trigger with arm=0, then a trigger while busy → no writes and evt_cnt unchanged. Then arm=1 with a fresh edge → evt_cnt increments by 1.
- evt_cnt preloaded to 0xFFFFFF via 2^24-1 events (or forced) → header A5FFFFFF, then evt_cnt=0; the next header is A5000000.
- Assert reset_reset mid-CAPTURE with write=1 → next cycle all outputs 0 and IDLE. The next armed trigger produces header A5000000.
